// File: rtl/adc_frame_capture.sv
// Captures one frame of ADC samples on wr_clk rising edges into a buffer, then
// streams the frame out over a valid/ready interface with no bubbles.
module adc_frame_capture #(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_clk,
    input  logic [1:0]        sw,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_done
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_PRIME   = 2'd2;
    localparam logic [1:0] S_STREAM  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              wr_clk_q;
    logic [1:0]        sw_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              tick_c;
    logic              sw_chg_c;
    logic              xfer_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] rd_next_c;

    assign tick_c    = wr_clk & ~wr_clk_q;
    assign sw_chg_c  = (sw != sw_q);
    assign xfer_c    = out_valid_q & out_ready;
    assign rd_next_c = rd_ptr_q + ADDR_W'(1);

    // Next-state and output decode; a rate change restarts the capture from slot 0.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        mem_we_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CAPTURE;
                    wr_ptr_d = '0;
                    busy_d   = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (sw_chg_c) begin
                    wr_ptr_d = '0;
                end else if (tick_c) begin
                    mem_we_c = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d  = S_PRIME;
                        rd_ptr_d = '0;
                    end
                end
            end
            S_PRIME: begin
                out_data_d  = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                out_last_d  = (rd_ptr_q == LAST_IDX);
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                // Fetch the following word on every accepted transfer to avoid bubbles.
                if (xfer_c) begin
                    if (out_last_q) begin
                        state_d      = S_IDLE;
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                    end else begin
                        rd_ptr_d   = rd_next_c;
                        out_data_d = mem_q[rd_next_c];
                        out_last_d = (rd_next_c == LAST_IDX);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_clk_q     <= 1'b0;
            sw_q         <= 2'b00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_clk_q     <= wr_clk;
            sw_q         <= sw;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // Sample buffer; contents are meaningless until a full frame has been written.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[wr_ptr_q] <= adc_data;
        end
    end

    assign busy       = busy_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;

endmodule
